fp_exp_align_pipe: RTL and testbench

//  Parametrised, pipelined exponent-compare and mantissa-align front end of the FP adder.
//  - Compares two operand exponents and routes the larger-exponent operand to the big path.
//  - Right-shifts the smaller operand's significand by the exponent difference, keeping guard/round/sticky bits.
//  - Sits between operand unpack and the significand add/normalise stage; valid/ready on both sides.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_rshift_sticky.sv | 32 +++
 rtl/fp_exp_align_pipe.sv | 163 ++++++++++++++++
 tb/tb_fp_exp_align_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared types and constants for the FP adder front end
//                (exponent compare / significand align).
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Default field widths for IEEE-754 single precision
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  // Guard and round bits appended below the significand LSB
  localparam int GRD_BITS = 2;

  // Unpacked operand at the default field widths
  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp_unpacked_t;

  // Shift at which every significand bit (hidden + frac + guard/round) has left
  function automatic int SAT_SHIFT(input int man_w);
    return man_w + 1 + GRD_BITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_rshift_sticky.sv
`default_nettype none
// ============================================================================
//  Module      : fp_rshift_sticky
//  Description : Combinational logical right shifter with a sticky OR of the
//                bits shifted out. The sticky tree is only built when
//                FP_ALIGN_STICKY_EN is defined; otherwise sticky is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_rshift_sticky #(
  parameter int WIDTH   = 26,
  parameter int SHAMT_W = 5
) (
  input  logic [WIDTH-1:0]   i_sig,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [WIDTH-1:0]   o_sig,
  output logic               o_sticky
);

  // Shift amounts >= WIDTH naturally yield zero
  assign o_sig = i_sig >> i_shamt;

`ifdef FP_ALIGN_STICKY_EN
  // Mask of the i_shamt lowest bits: exactly the bits that fall off the end
  logic [WIDTH-1:0] w_mask;
  assign w_mask   = ~({WIDTH{1'b1}} << i_shamt);
  assign o_sticky = |(i_sig & w_mask);
`else
  assign o_sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/fp_exp_align_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : fp_exp_align_pipe
//  Description : Two-stage exponent compare / significand align front end of
//                the FP adder. S1 compares exponents, swaps so the larger
//                exponent is "big" and clamps the shift; S2 right-aligns the
//                small significand with guard/round bits and sticky.
//                Valid/ready on both sides, throughput one pair per cycle.
//                Build option: FP_ALIGN_STICKY_EN enables sticky generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_exp_align_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               a_sign,
  input  logic [EXP_W-1:0]   a_exp,
  input  logic [MAN_W-1:0]   a_man,
  input  logic               b_sign,
  input  logic [EXP_W-1:0]   b_exp,
  input  logic [MAN_W-1:0]   b_man,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               lt,
  output logic [EXP_W-1:0]   exp_max,
  output logic               big_sign,
  output logic [MAN_W:0]     big_sig,
  output logic               small_sign,
  output logic [MAN_W+2:0]   small_sig,
  output logic               sticky,
  output logic [SHAMT_W-1:0] shamt,
  output logic               shift_sat
);

  localparam int c_sat_shift = SAT_SHIFT(MAN_W);
  localparam int c_aln_w     = MAN_W + 1 + GRD_BITS;

  // ---------------- S1 combinational compare / swap ----------------
  logic [EXP_W:0]   w_diff;
  logic [EXP_W:0]   w_mag;
  logic             w_lt;
  logic             w_sat;
  logic [SHAMT_W-1:0] w_shamt;
  logic [MAN_W:0]   w_a_sig;
  logic [MAN_W:0]   w_b_sig;

  assign w_diff  = {1'b0, a_exp} - {1'b0, b_exp};
  assign w_lt    = w_diff[EXP_W];
  assign w_mag   = w_lt ? -w_diff : w_diff;
  assign w_sat   = (w_mag >= (EXP_W+1)'(c_sat_shift));
  assign w_shamt = w_sat ? SHAMT_W'(c_sat_shift) : SHAMT_W'(w_mag);

  // Hidden bit is 0 only for a zero exponent (denormal or zero)
  assign w_a_sig = {|a_exp, a_man};
  assign w_b_sig = {|b_exp, b_man};

  // ---------------- handshake ----------------
  logic r1_valid;
  logic r2_valid;
  logic w_s2_can_load;
  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_can_load = ~r2_valid | out_ready;
  assign in_ready      = ~r1_valid | w_s2_can_load;
  assign w_s1_load     = in_valid & in_ready;
  assign w_s2_load     = r1_valid & w_s2_can_load;

  // ---------------- S1 registers ----------------
  logic               r1_lt;
  logic               r1_sat;
  logic [SHAMT_W-1:0] r1_shamt;
  logic [EXP_W-1:0]   r1_exp_max;
  logic               r1_big_sign;
  logic [MAN_W:0]     r1_big_sig;
  logic               r1_small_sign;
  logic [MAN_W:0]     r1_small_sig;

  // S1: capture the swapped operand pair and clamped shift on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid      <= 1'b0;
      r1_lt         <= 1'b0;
      r1_sat        <= 1'b0;
      r1_shamt      <= '0;
      r1_exp_max    <= '0;
      r1_big_sign   <= 1'b0;
      r1_big_sig    <= '0;
      r1_small_sign <= 1'b0;
      r1_small_sig  <= '0;
    end else begin
      if (in_ready) begin
        r1_valid <= in_valid;
      end
      if (w_s1_load) begin
        r1_lt         <= w_lt;
        r1_sat        <= w_sat;
        r1_shamt      <= w_shamt;
        r1_exp_max    <= w_lt ? b_exp   : a_exp;
        r1_big_sign   <= w_lt ? b_sign  : a_sign;
        r1_big_sig    <= w_lt ? w_b_sig : w_a_sig;
        r1_small_sign <= w_lt ? a_sign  : b_sign;
        r1_small_sig  <= w_lt ? w_a_sig : w_b_sig;
      end
    end
  end

  // ---------------- S2 align ----------------
  logic [c_aln_w-1:0] w_aln_sig;
  logic               w_sticky;

  fp_rshift_sticky #(
    .WIDTH   (c_aln_w),
    .SHAMT_W (SHAMT_W)
  ) u_rshift (
    .i_sig    ({r1_small_sig, {GRD_BITS{1'b0}}}),
    .i_shamt  (r1_shamt),
    .o_sig    (w_aln_sig),
    .o_sticky (w_sticky)
  );

  // S2: register the aligned result; hold while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid   <= 1'b0;
      lt         <= 1'b0;
      exp_max    <= '0;
      big_sign   <= 1'b0;
      big_sig    <= '0;
      small_sign <= 1'b0;
      small_sig  <= '0;
      sticky     <= 1'b0;
      shamt      <= '0;
      shift_sat  <= 1'b0;
    end else begin
      if (w_s2_can_load) begin
        r2_valid <= r1_valid;
      end
      if (w_s2_load) begin
        lt         <= r1_lt;
        exp_max    <= r1_exp_max;
        big_sign   <= r1_big_sign;
        big_sig    <= r1_big_sig;
        small_sign <= r1_small_sign;
        small_sig  <= w_aln_sig;
        sticky     <= w_sticky;
        shamt      <= r1_shamt;
        shift_sat  <= r1_sat;
      end
    end
  end

  assign out_valid = r2_valid;

endmodule
`default_nettype wire

// File: tb/tb_fp_exp_align_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_exp_align_pipe
//  Description : Scoreboard bench for fp_exp_align_pipe. Directed operand
//                pairs with hand-computed results; a monitor pops expected
//                results whenever the DUT transfers an output. Honours
//                FP_ALIGN_STICKY_EN for the expected sticky value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_exp_align_pipe;

`ifdef FP_ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  typedef struct packed {
    logic        lt;
    logic [7:0]  exp_max;
    logic        big_sign;
    logic [23:0] big_sig;
    logic        small_sign;
    logic [25:0] small_sig;
    logic        sticky;
    logic [4:0]  shamt;
    logic        shift_sat;
  } res_t;

  typedef struct packed {
    logic        a_sign;
    logic [7:0]  a_exp;
    logic [22:0] a_man;
    logic        b_sign;
    logic [7:0]  b_exp;
    logic [22:0] b_man;
  } pair_t;

  typedef struct {
    res_t r;
    bit   chk_lat;
    int   acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_man, b_man;
  logic        out_valid;
  logic        out_ready;
  logic        lt, big_sign, small_sign, sticky, shift_sat;
  logic [7:0]  exp_max;
  logic [23:0] big_sig;
  logic [25:0] small_sig;
  logic [4:0]  shamt;
  res_t        dut_res;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mode     = 0;  // 0: out_ready=1, 1: pattern 1,0,0, 2: out_ready=0
  exp_t sb[$];

  fp_exp_align_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_sign     (a_sign),
    .a_exp      (a_exp),
    .a_man      (a_man),
    .b_sign     (b_sign),
    .b_exp      (b_exp),
    .b_man      (b_man),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lt         (lt),
    .exp_max    (exp_max),
    .big_sign   (big_sign),
    .big_sig    (big_sig),
    .small_sign (small_sign),
    .small_sig  (small_sig),
    .sticky     (sticky),
    .shamt      (shamt),
    .shift_sat  (shift_sat)
  );

  assign dut_res = {lt, exp_max, big_sign, big_sig, small_sign, small_sig,
                    sticky, shamt, shift_sat};

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready pattern, updated just after each rising edge
  initial begin
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mode == 1) begin
        out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        out_ready = (mode == 0);
        ph = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic res_t mk(input logic l, input logic [7:0] em,
                              input logic bs, input logic [23:0] bsig,
                              input logic ss, input logic [25:0] ssig,
                              input logic st, input logic [4:0] sh,
                              input logic sat);
    res_t r;
    r.lt = l; r.exp_max = em; r.big_sign = bs; r.big_sig = bsig;
    r.small_sign = ss; r.small_sig = ssig; r.sticky = st;
    r.shamt = sh; r.shift_sat = sat;
    return r;
  endfunction

  function automatic pair_t mkp(input logic as, input logic [7:0] ae,
                                input logic [22:0] am, input logic bs,
                                input logic [7:0] be, input logic [22:0] bm);
    pair_t p;
    p.a_sign = as; p.a_exp = ae; p.a_man = am;
    p.b_sign = bs; p.b_exp = be; p.b_man = bm;
    return p;
  endfunction

  // Present a pair and wait (bounded) for it to be accepted
  task automatic send(input pair_t p, input res_t r, input bit lat);
    exp_t e;
    bit   done;
    done = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a_sign = p.a_sign; a_exp = p.a_exp; a_man = p.a_man;
      b_sign = p.b_sign; b_exp = p.b_exp; b_man = p.b_man;
      @(negedge clk);
      if (in_ready) begin
        e.r = r; e.chk_lat = lat; e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 30 cycles");
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(posedge clk); #4;
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results still outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: checks in_ready, hold stability and transferred results
  initial begin
    bit   held;
    res_t snap;
    exp_t e;
    logic exp_rdy;
    held = 1'b0;
    snap = '0;
    forever begin
      @(posedge clk); #3;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        exp_rdy = !(sb.size() == 2 && !out_ready);
        checks++;
        if (in_ready !== exp_rdy) begin
          failures++;
          $display("FAIL in_ready: got %b expected %b (inflight=%0d)",
                   in_ready, exp_rdy, sb.size());
        end
        if (held) begin
          checks++;
          if (out_valid !== 1'b1 || dut_res !== snap) begin
            failures++;
            $display("FAIL hold: got v=%b %h expected v=1 %h", out_valid, dut_res, snap);
          end
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output: got %h expected no output", dut_res);
          end else begin
            e = sb.pop_front();
            checks++;
            if (dut_res !== e.r) begin
              failures++;
              $display("FAIL result: got %h expected %h", dut_res, e.r);
            end
            if (e.chk_lat) begin
              checks++;
              if (cyc - e.acc != 2) begin
                failures++;
                $display("FAIL latency: got %0d expected 2", cyc - e.acc);
              end
            end
          end
        end
        held = out_valid && !out_ready;
        snap = dut_res;
      end
    end
  end

  initial begin
    pair_t p1, p2, p3, p6, p7, p8, p9;
    res_t  r1, r2, r3, r6, r7, r8, r9;

    p1 = mkp(1'b0, 8'h82, 23'h000000, 1'b1, 8'h80, 23'h400000);
    r1 = mk(1'b0, 8'h82, 1'b0, 24'h800000, 1'b1, 26'h0C00000, 1'b0, 5'd2, 1'b0);
    p2 = mkp(1'b1, 8'h7F, 23'h123456, 1'b0, 8'h9F, 23'h654321);
    r2 = mk(1'b1, 8'h9F, 1'b0, 24'hE54321, 1'b1, 26'h0, STK, 5'd26, 1'b1);
    p3 = mkp(1'b0, 8'h90, 23'h0AAAAA, 1'b1, 8'h90, 23'h555555);
    r3 = mk(1'b0, 8'h90, 1'b0, 24'h8AAAAA, 1'b1, 26'h3555554, 1'b0, 5'd0, 1'b0);
    p6 = mkp(1'b0, 8'h00, 23'h000001, 1'b0, 8'h01, 23'h000000);
    r6 = mk(1'b1, 8'h01, 1'b0, 24'h800000, 1'b0, 26'h0000002, 1'b0, 5'd1, 1'b0);
    p7 = mkp(1'b0, 8'h84, 23'h000000, 1'b0, 8'h80, 23'h000001);
    r7 = mk(1'b0, 8'h84, 1'b0, 24'h800000, 1'b0, 26'h0200000, STK, 5'd4, 1'b0);
    // Saturation boundary: diff 26 saturates, diff 25 does not
    p8 = mkp(1'b0, 8'h9A, 23'h000000, 1'b0, 8'h80, 23'h000000);
    r8 = mk(1'b0, 8'h9A, 1'b0, 24'h800000, 1'b0, 26'h0, STK, 5'd26, 1'b1);
    p9 = mkp(1'b0, 8'h99, 23'h000000, 1'b0, 8'h80, 23'h000000);
    r9 = mk(1'b0, 8'h99, 1'b0, 24'h800000, 1'b0, 26'h0000001, 1'b0, 5'd25, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0;
    a_sign = 1'b0; a_exp = '0; a_man = '0;
    b_sign = 1'b0; b_exp = '0; b_man = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_res !== '0) begin
      failures++;
      $display("FAIL reset_state: got v=%b %h expected v=0 0", out_valid, dut_res);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end

    // Isolated directed pairs with latency checks
    send(p1, r1, 1'b1); idle(); drain(20);
    send(p2, r2, 1'b1); idle(); drain(20);
    send(p3, r3, 1'b1); idle(); drain(20);
    send(p6, r6, 1'b1); idle(); drain(20);
    send(p7, r7, 1'b1); idle(); drain(20);
    send(p8, r8, 1'b1); idle(); drain(20);
    send(p9, r9, 1'b1); idle(); drain(20);

    // Back-to-back burst under a 1,0,0 ready pattern
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0]  ei;
      logic [25:0] si;
      ei = 8'h80 + 8'(i);
      si = 26'h2000000 >> i;
      send(mkp(i[0], ei, 23'(i), 1'b0, 8'h80, 23'h0),
           mk(1'b0, ei, i[0], 24'h800000 | 24'(i), 1'b0, si, 1'b0, 5'(i), 1'b0),
           1'b0);
    end
    idle();
    drain(100);
    mode = 0;
    repeat (2) @(posedge clk);

    // Reset with two pairs in flight, then one pair alone
    mode = 2;
    send(p1, r1, 1'b0);
    send(p3, r3, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_res !== '0) begin
      failures++;
      $display("FAIL reset_flush: got v=%b %h expected v=0 0", out_valid, dut_res);
    end
    sb.delete();
    mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(p6, r6, 1'b1); idle(); drain(20);
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
